// File: rtl/tl_crossing_arbiter.sv
// tl_crossing_arbiter
//   Shares one single-beat TileLink-UL crossing among N_REQ requesters.
//   A channels are arbitrated round-robin into the crossing. Each request
//   takes one of two downstream source slots. The D response for a slot is
//   sent back to the requester that owns it, with the requester's original
//   source bit restored. The quiesce/idle handshake lets a controller drain
//   the crossing before resetting it.
//
// Ports
//   clock, reset              clock; asynchronous active-low reset
//   req_a_*                   packed per-requester A channels (valid/ready per requester)
//   req_d_valid/ready         per-requester D handshake
//   req_d_opcode/size/source/data
//                             shared D bits, qualified by req_d_valid
//   out_a_*                   crossing A channel (source = allocated slot)
//   out_d_*                   crossing D channel (source = slot)
//   quiesce                   blocks new grants; a locked offer still completes
//   idle                      no slot busy and no locked A offer
//   err_unexpected_d          sticky: a D beat arrived for a free slot
//
// state          | meaning
// ---------------+------------------------------------------------------------
// lock_valid_q=0 | no stalled offer; the grant is chosen afresh every cycle
// lock_valid_q=1 | offer stalled on out_a_ready; grant and slot are held stable
module tl_crossing_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_a_valid,
    output logic [N_REQ-1:0]     req_a_ready,
    input  logic [3*N_REQ-1:0]   req_a_opcode,
    input  logic [3*N_REQ-1:0]   req_a_param,
    input  logic [2*N_REQ-1:0]   req_a_size,
    input  logic [N_REQ-1:0]     req_a_source,
    input  logic [9*N_REQ-1:0]   req_a_address,
    input  logic [4*N_REQ-1:0]   req_a_mask,
    input  logic [32*N_REQ-1:0]  req_a_data,
    input  logic [N_REQ-1:0]     req_a_corrupt,
    output logic [N_REQ-1:0]     req_d_valid,
    input  logic [N_REQ-1:0]     req_d_ready,
    output logic [2:0]           req_d_opcode,
    output logic [1:0]           req_d_size,
    output logic                 req_d_source,
    output logic [31:0]          req_d_data,
    output logic                 out_a_valid,
    input  logic                 out_a_ready,
    output logic [2:0]           out_a_bits_opcode,
    output logic [2:0]           out_a_bits_param,
    output logic [1:0]           out_a_bits_size,
    output logic                 out_a_bits_source,
    output logic [8:0]           out_a_bits_address,
    output logic [3:0]           out_a_bits_mask,
    output logic [31:0]          out_a_bits_data,
    output logic                 out_a_bits_corrupt,
    input  logic                 out_d_valid,
    output logic                 out_d_ready,
    input  logic [2:0]           out_d_bits_opcode,
    input  logic [1:0]           out_d_bits_size,
    input  logic                 out_d_bits_source,
    input  logic [31:0]          out_d_bits_data,
    input  logic                 quiesce,
    output logic                 idle,
    output logic                 err_unexpected_d
);

    localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [IW-1:0] rr_q;
    logic          lock_valid_q;
    logic [IW-1:0] lock_idx_q;
    logic          lock_slot_q;
    logic [1:0]    busy_q;
    logic [IW-1:0] owner_q [2];
    logic          src_q   [2];
    logic          err_q;

    logic          free_slot;
    logic          slot_avail;
    logic          scan_found;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] grant;
    logic          alloc_slot;
    logic          offer;
    logic          a_fire;
    logic          d_slot;
    logic          d_busy;
    logic [IW-1:0] d_owner;
    logic          d_owner_ready;
    logic          d_fire;

    assign free_slot  = busy_q[0];
    assign slot_avail = ~(busy_q[0] & busy_q[1]);

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % N_REQ;
            if (!scan_found && req_a_valid[idx]) begin
                scan_found = 1'b1;
                scan_idx   = IW'(idx);
            end
        end
    end

    assign grant = lock_valid_q ? lock_idx_q : scan_idx;
    // A locked offer keeps the slot it was given when it stalled. A D fire
    // during the stall may free a lower slot, and the source must not move.
    assign alloc_slot = lock_valid_q ? lock_slot_q : free_slot;
    // Outputs are gated by reset so nothing handshakes while reset is held.
    assign offer  = reset & (lock_valid_q | (scan_found & slot_avail & ~quiesce));
    assign a_fire = offer & out_a_ready;

    always_comb begin
        int gi;
        gi                 = int'(grant);
        out_a_valid        = offer;
        out_a_bits_opcode  = req_a_opcode[3*gi +: 3];
        out_a_bits_param   = req_a_param[3*gi +: 3];
        out_a_bits_size    = req_a_size[2*gi +: 2];
        out_a_bits_source  = alloc_slot;
        out_a_bits_address = req_a_address[9*gi +: 9];
        out_a_bits_mask    = req_a_mask[4*gi +: 4];
        out_a_bits_data    = req_a_data[32*gi +: 32];
        out_a_bits_corrupt = req_a_corrupt[gi];
        for (int i = 0; i < N_REQ; i++) begin
            req_a_ready[i] = a_fire & (grant == IW'(i));
        end
    end

    assign d_slot  = out_d_bits_source;
    assign d_busy  = busy_q[d_slot];
    assign d_owner = owner_q[d_slot];

    always_comb begin
        d_owner_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_d_valid[i] = reset & d_busy & out_d_valid & (d_owner == IW'(i));
            if (d_owner == IW'(i)) begin
                d_owner_ready = req_d_ready[i];
            end
        end
    end

    // A beat for a free slot is accepted and dropped so the crossing never
    // wedges on it.
    assign out_d_ready  = reset & (d_busy ? d_owner_ready : 1'b1);
    assign d_fire       = out_d_valid & out_d_ready;
    assign req_d_opcode = out_d_bits_opcode;
    assign req_d_size   = out_d_bits_size;
    assign req_d_source = src_q[d_slot];
    assign req_d_data   = out_d_bits_data;

    assign idle             = ~busy_q[0] & ~busy_q[1] & ~lock_valid_q;
    assign err_unexpected_d = err_q;

    // A and D can fire in the same cycle without touching the same slot:
    // allocation only picks a slot that is already free in busy_q, and D only
    // clears a slot that is marked busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q         <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            lock_slot_q  <= 1'b0;
            busy_q       <= 2'b00;
            owner_q[0]   <= '0;
            owner_q[1]   <= '0;
            src_q[0]     <= 1'b0;
            src_q[1]     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (d_fire && d_busy) begin
                busy_q[d_slot] <= 1'b0;
            end
            if (d_fire && !d_busy) begin
                err_q <= 1'b1;
            end
            if (a_fire) begin
                busy_q[alloc_slot]  <= 1'b1;
                owner_q[alloc_slot] <= grant;
                src_q[alloc_slot]   <= req_a_source[grant];
                rr_q                <= (grant == IW'(N_REQ-1)) ? '0 : grant + 1'b1;
                lock_valid_q        <= 1'b0;
            end else if (offer) begin
                lock_valid_q <= 1'b1;
                lock_idx_q   <= grant;
                lock_slot_q  <= alloc_slot;
            end
        end
    end

endmodule

// File: tb/tb_tl_crossing_arbiter.sv
// tb_tl_crossing_arbiter
//   Directed bench for tl_crossing_arbiter with N_REQ=2. Inputs change 1 ns
//   after a rising edge and outputs are sampled 1 ns later.
module tb_tl_crossing_arbiter;

    localparam int N = 2;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_a_valid;
    logic [N-1:0]    req_a_ready;
    logic [3*N-1:0]  req_a_opcode;
    logic [3*N-1:0]  req_a_param;
    logic [2*N-1:0]  req_a_size;
    logic [N-1:0]    req_a_source;
    logic [9*N-1:0]  req_a_address;
    logic [4*N-1:0]  req_a_mask;
    logic [32*N-1:0] req_a_data;
    logic [N-1:0]    req_a_corrupt;
    logic [N-1:0]    req_d_valid;
    logic [N-1:0]    req_d_ready;
    logic [2:0]      req_d_opcode;
    logic [1:0]      req_d_size;
    logic            req_d_source;
    logic [31:0]     req_d_data;
    logic            out_a_valid;
    logic            out_a_ready;
    logic [2:0]      out_a_bits_opcode;
    logic [2:0]      out_a_bits_param;
    logic [1:0]      out_a_bits_size;
    logic            out_a_bits_source;
    logic [8:0]      out_a_bits_address;
    logic [3:0]      out_a_bits_mask;
    logic [31:0]     out_a_bits_data;
    logic            out_a_bits_corrupt;
    logic            out_d_valid;
    logic            out_d_ready;
    logic [2:0]      out_d_bits_opcode;
    logic [1:0]      out_d_bits_size;
    logic            out_d_bits_source;
    logic [31:0]     out_d_bits_data;
    logic            quiesce;
    logic            idle;
    logic            err_unexpected_d;

    int checks = 0;
    int errors = 0;

    tl_crossing_arbiter #(.N_REQ(N)) dut (
        .clock              (clock),
        .reset              (reset),
        .req_a_valid        (req_a_valid),
        .req_a_ready        (req_a_ready),
        .req_a_opcode       (req_a_opcode),
        .req_a_param        (req_a_param),
        .req_a_size         (req_a_size),
        .req_a_source       (req_a_source),
        .req_a_address      (req_a_address),
        .req_a_mask         (req_a_mask),
        .req_a_data         (req_a_data),
        .req_a_corrupt      (req_a_corrupt),
        .req_d_valid        (req_d_valid),
        .req_d_ready        (req_d_ready),
        .req_d_opcode       (req_d_opcode),
        .req_d_size         (req_d_size),
        .req_d_source       (req_d_source),
        .req_d_data         (req_d_data),
        .out_a_valid        (out_a_valid),
        .out_a_ready        (out_a_ready),
        .out_a_bits_opcode  (out_a_bits_opcode),
        .out_a_bits_param   (out_a_bits_param),
        .out_a_bits_size    (out_a_bits_size),
        .out_a_bits_source  (out_a_bits_source),
        .out_a_bits_address (out_a_bits_address),
        .out_a_bits_mask    (out_a_bits_mask),
        .out_a_bits_data    (out_a_bits_data),
        .out_a_bits_corrupt (out_a_bits_corrupt),
        .out_d_valid        (out_d_valid),
        .out_d_ready        (out_d_ready),
        .out_d_bits_opcode  (out_d_bits_opcode),
        .out_d_bits_size    (out_d_bits_size),
        .out_d_bits_source  (out_d_bits_source),
        .out_d_bits_data    (out_d_bits_data),
        .quiesce            (quiesce),
        .idle               (idle),
        .err_unexpected_d   (err_unexpected_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [8:0] addr,
                           input logic [31:0] data, input logic src);
        req_a_valid[i]           = v;
        req_a_opcode[3*i +: 3]   = 3'd4;
        req_a_param[3*i +: 3]    = 3'd0;
        req_a_size[2*i +: 2]     = 2'd2;
        req_a_source[i]          = src;
        req_a_address[9*i +: 9]  = addr;
        req_a_mask[4*i +: 4]     = 4'hf;
        req_a_data[32*i +: 32]   = data;
        req_a_corrupt[i]         = 1'b0;
    endtask

    task automatic set_d(input logic v, input logic src, input logic [31:0] data);
        out_d_valid       = v;
        out_d_bits_source = src;
        out_d_bits_opcode = 3'd1;
        out_d_bits_size   = 2'd2;
        out_d_bits_data   = data;
    endtask

    task automatic clear_inputs();
        req_a_valid   = '0;
        req_a_opcode  = '0;
        req_a_param   = '0;
        req_a_size    = '0;
        req_a_source  = '0;
        req_a_address = '0;
        req_a_mask    = '0;
        req_a_data    = '0;
        req_a_corrupt = '0;
        req_d_ready   = '0;
        out_a_ready   = 1'b0;
        quiesce       = 1'b0;
        set_d(1'b0, 1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        // Reset with live stimulus: nothing may handshake.
        set_req(0, 1'b1, 9'h04, 32'h0, 1'b0);
        set_d(1'b1, 1'b1, 32'h0);
        out_a_ready = 1'b1;
        #3;
        chk("rst_a_valid", out_a_valid, 0);
        chk("rst_a_ready", req_a_ready, 0);
        chk("rst_d_ready", out_d_ready, 0);
        chk("rst_d_valid", req_d_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_unexpected_d, 0);
        clear_inputs();
        #4;
        reset = 1'b1;
        tick();

        // Single request with restored source.
        set_req(0, 1'b1, 9'h04, 32'h0, 1'b1);
        out_a_ready = 1'b1;
        #1;
        chk("t1_a_valid", out_a_valid, 1);
        chk("t1_a_src", out_a_bits_source, 0);
        chk("t1_a_addr", out_a_bits_address, 9'h04);
        chk("t1_a_op", out_a_bits_opcode, 3'd4);
        chk("t1_a_ready", req_a_ready, 2'b01);
        tick();
        req_a_valid = '0;
        out_a_ready = 1'b0;
        set_d(1'b1, 1'b0, 32'hDEADBEEF);
        req_d_ready = 2'b01;
        #1;
        chk("t1_idle_busy", idle, 0);
        chk("t1_d_valid", req_d_valid, 2'b01);
        chk("t1_d_src", req_d_source, 1);
        chk("t1_d_data", req_d_data, 32'hDEADBEEF);
        chk("t1_d_ready", out_d_ready, 1);
        tick();
        set_d(1'b0, 1'b0, 32'h0);
        #1;
        chk("t1_idle", idle, 1);

        // Round robin with D retiring one cycle behind.
        apply_reset();
        set_req(0, 1'b1, 9'h0A0, 32'hA0A0A0A0, 1'b0);
        set_req(1, 1'b1, 9'h0B1, 32'hB1B1B1B1, 1'b1);
        out_a_ready = 1'b1;
        req_d_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) set_d(1'b1, 1'((c-1) % 2), 32'h0);
            #1;
            chk("rr_grant", req_a_ready, (c % 2) ? 2'b10 : 2'b01);
            chk("rr_slot", out_a_bits_source, c % 2);
            chk("rr_data", out_a_bits_data, (c % 2) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
            if (c > 0) begin
                chk("rr_d_owner", req_d_valid, ((c-1) % 2) ? 2'b10 : 2'b01);
                chk("rr_d_src", req_d_source, (c-1) % 2);
            end
            tick();
        end
        req_a_valid = '0;
        set_d(1'b1, 1'b1, 32'h0);
        #1;
        chk("rr_last_d", req_d_valid, 2'b10);
        tick();
        set_d(1'b0, 1'b0, 32'h0);
        #1;
        chk("rr_idle", idle, 1);

        // Stall lock, then slot exhaustion.
        apply_reset();
        set_req(1, 1'b1, 9'h010, 32'h11111111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) quiesce = 1'b1;
            #1;
            chk("lk_a_valid", out_a_valid, 1);
            chk("lk_a_ready", req_a_ready, 0);
            chk("lk_addr", out_a_bits_address, 9'h010);
            tick();
        end
        set_req(0, 1'b1, 9'h020, 32'h22222222, 1'b1);
        #1;
        chk("lk_hold_data", out_a_bits_data, 32'h11111111);
        chk("lk_hold_src", out_a_bits_source, 0);
        chk("lk_idle", idle, 0);
        quiesce = 1'b0;
        out_a_ready = 1'b1;
        #1;
        chk("lk_fire", req_a_ready, 2'b10);
        tick();
        req_a_valid[1] = 1'b0;
        #1;
        chk("lk_next_grant", req_a_ready, 2'b01);
        chk("lk_next_slot", out_a_bits_source, 1);
        chk("lk_next_addr", out_a_bits_address, 9'h020);
        tick();
        set_req(0, 1'b1, 9'h030, 32'h33333333, 1'b0);
        #1;
        chk("ex_no_offer", out_a_valid, 0);
        chk("ex_idle", idle, 0);
        tick();
        set_d(1'b1, 1'b1, 32'h0);
        req_d_ready = 2'b01;
        #1;
        chk("ex_d_owner", req_d_valid, 2'b01);
        chk("ex_d_src", req_d_source, 1);
        chk("ex_still_full", out_a_valid, 0);
        tick();
        set_d(1'b0, 1'b0, 32'h0);
        #1;
        chk("ex_reoffer", out_a_valid, 1);
        chk("ex_reslot", out_a_bits_source, 1);
        chk("ex_redata", out_a_bits_data, 32'h33333333);

        // Quiesce, drain, then an asynchronous reset mid-operation.
        apply_reset();
        set_req(0, 1'b1, 9'h004, 32'h0, 1'b0);
        out_a_ready = 1'b1;
        tick();
        req_a_valid = '0;
        quiesce = 1'b1;
        set_req(1, 1'b1, 9'h044, 32'h44444444, 1'b1);
        #1;
        chk("q_block", out_a_valid, 0);
        chk("q_idle_busy", idle, 0);
        tick();
        set_d(1'b1, 1'b0, 32'h0);
        req_d_ready = 2'b01;
        #1;
        chk("q_d_ready", out_d_ready, 1);
        tick();
        set_d(1'b0, 1'b0, 32'h0);
        #1;
        chk("q_idle", idle, 1);
        chk("q_still_block", out_a_valid, 0);
        quiesce = 1'b0;
        #1;
        chk("q_release", req_a_ready, 2'b10);
        tick();
        req_a_valid = '0;
        #1;
        chk("ar_busy", idle, 0);
        set_req(0, 1'b1, 9'h004, 32'h0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_idle", idle, 1);
        chk("ar_a_valid", out_a_valid, 0);
        chk("ar_a_ready", req_a_ready, 0);
        clear_inputs();
        reset = 1'b1;
        tick();

        // Stray D to a free slot.
        set_d(1'b1, 1'b1, 32'h0);
        #1;
        chk("st_d_ready", out_d_ready, 1);
        chk("st_d_valid", req_d_valid, 0);
        chk("st_err_pre", err_unexpected_d, 0);
        tick();
        set_d(1'b0, 1'b0, 32'h0);
        #1;
        chk("st_err", err_unexpected_d, 1);
        tick();
        tick();
        tick();
        chk("st_err_held", err_unexpected_d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
